// File: rtl/ddr4_cmd_scheduler.sv
// In-order, open-page DDR4 command scheduler: takes one queued request at a time,
// tracks the open row of all 16 banks and issues PRE/ACT/RD/WR while honouring tRCD/tRP/tRAS/CL/CWL.
module ddr4_cmd_scheduler #(
    parameter int T_RCD   = 24,
    parameter int T_RP    = 24,
    parameter int T_RAS   = 52,
    parameter int T_CL    = 24,
    parameter int T_CWL   = 20,
    parameter int T_BURST = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [1:0]  i_req_op,
    input  logic [32:0] i_req_addr,
    output logic        o_cmd_valid,
    output logic [2:0]  o_cmd_type,
    output logic [1:0]  o_cmd_bg,
    output logic [1:0]  o_cmd_bank,
    output logic [14:0] o_cmd_row,
    output logic [10:0] o_cmd_col,
    output logic        o_done_valid,
    output logic [31:0] o_hit_cnt,
    output logic [31:0] o_miss_cnt,
    output logic [31:0] o_conflict_cnt
);

    localparam logic [2:0] CMD_NOP = 3'd0;
    localparam logic [2:0] CMD_ACT = 3'd1;
    localparam logic [2:0] CMD_RD  = 3'd2;
    localparam logic [2:0] CMD_WR  = 3'd3;
    localparam logic [2:0] CMD_PRE = 3'd4;

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_PRE, S_ACT, S_CAS, S_DATA} state_t;

    state_t      r_state, w_nextState, w_target;
    logic        r_reqReady, r_write, r_cmdValid, r_doneValid;
    logic [1:0]  r_bg, r_bank, r_cmdBg, r_cmdBank;
    logic [14:0] r_row, r_cmdRow;
    logic [10:0] r_col, r_cmdCol;
    logic [2:0]  r_cmdType, w_issueType;
    logic [7:0]  r_wait, w_waitLoad;
    logic [31:0] r_hitCnt, r_missCnt, r_conflictCnt;
    logic [15:0] r_open;
    logic [14:0] r_openRow  [16];
    logic [7:0]  r_rasTimer [16];
    logic        w_handshake, w_issue, w_done;
    logic [3:0]  w_bankIdx;
    logic        w_unusedAddr;

    assign w_bankIdx    = {r_bg, r_bank};
    assign w_handshake  = r_reqReady & i_req_valid;
    assign w_unusedAddr = ^i_req_addr[2:0];

    // CHECK resolves straight into the first command's state so that command can go out on the CHECK edge.
    always_comb begin
        w_target = r_state;
        if (r_state == S_CHECK) begin
            if (!r_open[w_bankIdx])
                w_target = S_ACT;
            else if (r_openRow[w_bankIdx] == r_row)
                w_target = S_CAS;
            else
                w_target = S_PRE;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_issue     = 1'b0;
        w_issueType = CMD_NOP;
        w_waitLoad  = 8'd0;
        w_done      = 1'b0;
        case (w_target)
            S_IDLE: if (w_handshake) w_nextState = S_CHECK;
            S_PRE: begin
                w_nextState = S_PRE;
                if (r_wait == 8'd0 && r_rasTimer[w_bankIdx] == 8'd0) begin
                    w_issue     = 1'b1;
                    w_issueType = CMD_PRE;
                    w_waitLoad  = 8'(T_RP - 1);
                    w_nextState = S_ACT;
                end
            end
            S_ACT: begin
                w_nextState = S_ACT;
                if (r_wait == 8'd0) begin
                    w_issue     = 1'b1;
                    w_issueType = CMD_ACT;
                    w_waitLoad  = 8'(T_RCD - 1);
                    w_nextState = S_CAS;
                end
            end
            S_CAS: begin
                w_nextState = S_CAS;
                if (r_wait == 8'd0) begin
                    w_issue     = 1'b1;
                    w_issueType = r_write ? CMD_WR : CMD_RD;
                    w_waitLoad  = r_write ? 8'(T_CWL + T_BURST - 1) : 8'(T_CL + T_BURST - 1);
                    w_nextState = S_DATA;
                end
            end
            S_DATA: begin
                w_nextState = S_DATA;
                if (r_wait == 8'd0) begin
                    w_done      = 1'b1;
                    w_nextState = S_IDLE;
                end
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_nextState;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_reqReady    <= 1'b0;
            r_write       <= 1'b0;
            r_bg          <= '0;
            r_bank        <= '0;
            r_row         <= '0;
            r_col         <= '0;
            r_cmdValid    <= 1'b0;
            r_cmdType     <= CMD_NOP;
            r_cmdBg       <= '0;
            r_cmdBank     <= '0;
            r_cmdRow      <= '0;
            r_cmdCol      <= '0;
            r_doneValid   <= 1'b0;
            r_wait        <= '0;
            r_hitCnt      <= '0;
            r_missCnt     <= '0;
            r_conflictCnt <= '0;
        end else begin
            r_reqReady <= (w_nextState == S_IDLE);
            if (w_handshake) begin
                r_write <= (i_req_op == 2'd1);
                r_bg    <= i_req_addr[7:6];
                r_bank  <= i_req_addr[9:8];
                r_row   <= i_req_addr[32:18];
                r_col   <= {i_req_addr[17:10], i_req_addr[5:3]};
            end
            r_cmdValid <= w_issue;
            r_cmdType  <= w_issueType;
            if (w_issue) begin
                r_cmdBg   <= r_bg;
                r_cmdBank <= r_bank;
                r_cmdRow  <= r_row;
                r_cmdCol  <= (w_issueType == CMD_PRE) ? 11'd0 : r_col;
            end
            r_doneValid <= w_done;
            // One shared countdown paces the gap to the next command or to completion.
            if (w_issue)
                r_wait <= w_waitLoad;
            else if (r_wait != 8'd0)
                r_wait <= r_wait - 8'd1;
            if (r_state == S_CHECK) begin
                case (w_target)
                    S_CAS:   if (r_hitCnt != '1) r_hitCnt <= r_hitCnt + 32'd1;
                    S_ACT:   if (r_missCnt != '1) r_missCnt <= r_missCnt + 32'd1;
                    default: if (r_conflictCnt != '1) r_conflictCnt <= r_conflictCnt + 32'd1;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_open <= '0;
            for (int i = 0; i < 16; i++) begin
                r_openRow[i]  <= '0;
                r_rasTimer[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 16; i++)
                if (r_rasTimer[i] != 8'd0) r_rasTimer[i] <= r_rasTimer[i] - 8'd1;
            if (w_issue && w_issueType == CMD_ACT) begin
                r_open[w_bankIdx]     <= 1'b1;
                r_openRow[w_bankIdx]  <= r_row;
                r_rasTimer[w_bankIdx] <= 8'(T_RAS - 1);
            end
            if (w_issue && w_issueType == CMD_PRE)
                r_open[w_bankIdx] <= 1'b0;
        end
    end

    assign o_req_ready    = r_reqReady;
    assign o_cmd_valid    = r_cmdValid;
    assign o_cmd_type     = r_cmdType;
    assign o_cmd_bg       = r_cmdBg;
    assign o_cmd_bank     = r_cmdBank;
    assign o_cmd_row      = r_cmdRow;
    assign o_cmd_col      = r_cmdCol;
    assign o_done_valid   = r_doneValid;
    assign o_hit_cnt      = r_hitCnt;
    assign o_miss_cnt     = r_missCnt;
    assign o_conflict_cnt = r_conflictCnt;

endmodule

// File: tb/tb_ddr4_cmd_scheduler.sv
// Bench for ddr4_cmd_scheduler: directed and random requests checked against a
// per-request timeline model (bank open rows and last-ACT edges).
module tb_ddr4_cmd_scheduler;

    localparam int T_RCD   = 24;
    localparam int T_RP    = 24;
    localparam int T_RAS   = 52;
    localparam int T_CL    = 24;
    localparam int T_CWL   = 20;
    localparam int T_BURST = 4;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_req_valid = 1'b0;
    logic [1:0]  i_req_op = 2'd0;
    logic [32:0] i_req_addr = '0;
    logic        o_req_ready, o_cmd_valid, o_done_valid;
    logic [2:0]  o_cmd_type;
    logic [1:0]  o_cmd_bg, o_cmd_bank;
    logic [14:0] o_cmd_row;
    logic [10:0] o_cmd_col;
    logic [31:0] o_hit_cnt, o_miss_cnt, o_conflict_cnt;

    int checks = 0;
    int errors = 0;
    int edgeNum = 0;
    int lastDone = -1;
    bit prevKept = 0;

    bit mOpen    [16];
    int mRow     [16];
    int mLastAct [16];
    int mHit, mMiss, mConf;

    logic [32:0] addr;
    logic [1:0]  op;
    bit          keep;

    ddr4_cmd_scheduler dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_op(i_req_op), .i_req_addr(i_req_addr), .o_cmd_valid(o_cmd_valid),
        .o_cmd_type(o_cmd_type), .o_cmd_bg(o_cmd_bg), .o_cmd_bank(o_cmd_bank),
        .o_cmd_row(o_cmd_row), .o_cmd_col(o_cmd_col), .o_done_valid(o_done_valid),
        .o_hit_cnt(o_hit_cnt), .o_miss_cnt(o_miss_cnt), .o_conflict_cnt(o_conflict_cnt)
    );

    always #5 i_clk = ~i_clk;

    task automatic step();
        @(posedge i_clk);
        edgeNum++;
        @(negedge i_clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s at edge %0d: observed 0x%0h expected 0x%0h", tag, edgeNum, obs, exp);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 16; i++) begin
            mOpen[i]    = 0;
            mRow[i]     = 0;
            mLastAct[i] = 0;
        end
        mHit = 0; mMiss = 0; mConf = 0;
        lastDone = -1;
        prevKept = 0;
    endtask

    task automatic checkCounters();
        checkOutput("hit_cnt", o_hit_cnt, mHit);
        checkOutput("miss_cnt", o_miss_cnt, mMiss);
        checkOutput("conflict_cnt", o_conflict_cnt, mConf);
    endtask

    task automatic doReset();
        i_rst_n = 1'b0;
        i_req_valid = 1'b0;
        step(); step(); step();
        i_rst_n = 1'b1;
        modelReset();
        step();
        checkOutput("ready_after_reset", o_req_ready, 1);
    endtask

    // One request: handshake, derive the expected command timeline, then check every edge to done.
    task automatic applyStimulus(input logic [1:0] reqOp, input logic [32:0] reqAddr, input bit holdValid);
        int waitCnt, k, b, row, col, pre, act, cas, done;
        bit isWrite, isCmd;
        logic [2:0] expType;
        i_req_valid = 1'b1;
        i_req_op    = reqOp;
        i_req_addr  = reqAddr;
        waitCnt = 0;
        while (o_req_ready !== 1'b1 && waitCnt < 300) begin
            step();
            waitCnt++;
        end
        if (o_req_ready !== 1'b1) begin
            checkOutput("ready_timeout", o_req_ready, 1);
            i_req_valid = 1'b0;
            return;
        end
        step();
        k = edgeNum;
        if (prevKept && lastDone >= 0) checkOutput("b2b_handshake", k, lastDone + 1);
        if (!holdValid) i_req_valid = 1'b0;
        prevKept = holdValid;

        isWrite = (reqOp == 2'd1);
        b   = int'((reqAddr >> 6) & 3) * 4 + int'((reqAddr >> 8) & 3);
        row = int'((reqAddr >> 18) & 33'h7FFF);
        col = int'(((reqAddr >> 10) & 255) * 8 + ((reqAddr >> 3) & 7));
        pre = -1;
        act = -1;
        if (mOpen[b] && mRow[b] == row) begin
            mHit++;
            cas = k + 1;
        end else if (mOpen[b]) begin
            mConf++;
            pre = (k + 1 > mLastAct[b] + T_RAS) ? k + 1 : mLastAct[b] + T_RAS;
            act = pre + T_RP;
            cas = act + T_RCD;
        end else begin
            mMiss++;
            act = k + 1;
            cas = act + T_RCD;
        end
        done = cas + (isWrite ? T_CWL : T_CL) + T_BURST;
        if (act >= 0) begin
            mOpen[b]    = 1;
            mRow[b]     = row;
            mLastAct[b] = act;
        end

        forever begin
            isCmd = (edgeNum == pre) || (edgeNum == act) || (edgeNum == cas);
            checkOutput("cmd_valid", o_cmd_valid, isCmd);
            if (isCmd) begin
                expType = (edgeNum == pre) ? 3'd4 : (edgeNum == act) ? 3'd1 : (isWrite ? 3'd3 : 3'd2);
                checkOutput("cmd_type", o_cmd_type, expType);
                checkOutput("cmd_bg", o_cmd_bg, b / 4);
                checkOutput("cmd_bank", o_cmd_bank, b % 4);
                if (edgeNum == act) checkOutput("act_row", o_cmd_row, row);
                if (edgeNum == cas) checkOutput("cas_col", o_cmd_col, col);
                if (edgeNum == pre) checkOutput("pre_col", o_cmd_col, 0);
            end else begin
                checkOutput("cmd_type_nop", o_cmd_type, 0);
            end
            checkOutput("done_valid", o_done_valid, edgeNum == done);
            checkOutput("req_ready", o_req_ready, edgeNum == done);
            if (edgeNum >= done) break;
            step();
        end
        checkCounters();
        lastDone = done;
    endtask

    initial begin
        modelReset();
        step(); step();
        checkOutput("rst_ready", o_req_ready, 0);
        checkOutput("rst_cmd_valid", o_cmd_valid, 0);
        checkOutput("rst_cmd_type", o_cmd_type, 0);
        checkOutput("rst_cmd_fields", {o_cmd_bg, o_cmd_bank, o_cmd_row, o_cmd_col}, 0);
        checkOutput("rst_done", o_done_valid, 0);
        checkCounters();
        i_rst_n = 1'b1;
        step();
        checkOutput("ready_after_release", o_req_ready, 1);

        $display("[TB] miss then page hit");
        applyStimulus(2'd0, 33'h0, 0);
        applyStimulus(2'd0, 33'h8, 0);

        $display("[TB] tRAS-limited row conflict");
        doReset();
        applyStimulus(2'd1, 33'h0, 0);
        applyStimulus(2'd0, 33'h40000, 0);

        $display("[TB] independent banks stay open");
        doReset();
        applyStimulus(2'd0, 33'h0, 0);
        applyStimulus(2'd0, 33'h140040, 0);
        applyStimulus(2'd0, 33'h0, 0);

        $display("[TB] reset during an in-flight miss");
        doReset();
        i_req_valid = 1'b1;
        i_req_op    = 2'd0;
        i_req_addr  = 33'h1_2345_66C8;
        step();
        i_req_valid = 1'b0;
        for (int i = 0; i < 11; i++) step();
        i_rst_n = 1'b0;
        #1;
        checkOutput("async_cmd_valid", o_cmd_valid, 0);
        checkOutput("async_cmd_type", o_cmd_type, 0);
        checkOutput("async_cmd_fields", {o_cmd_bg, o_cmd_bank, o_cmd_row, o_cmd_col}, 0);
        checkOutput("async_ready", o_req_ready, 0);
        step(); step(); step();
        i_rst_n = 1'b1;
        modelReset();
        for (int i = 0; i < 60; i++) begin
            step();
            checkOutput("dropped_done", o_done_valid, 0);
            checkOutput("dropped_cmd", o_cmd_valid, 0);
        end
        applyStimulus(2'd0, 33'h1_2345_66C8, 0);

        $display("[TB] continuous write stream");
        for (int i = 0; i < 6; i++) begin
            addr = {15'($urandom_range(0, 2)), 8'($urandom), 2'($urandom_range(0, 1)),
                    2'($urandom_range(0, 1)), 3'($urandom), 3'($urandom)};
            applyStimulus(2'd1, addr, 1);
        end
        i_req_valid = 1'b0;

        $display("[TB] random mix");
        for (int i = 0; i < 24; i++) begin
            addr = {15'($urandom_range(0, 2)), 8'($urandom), 2'($urandom_range(0, 1)),
                    2'($urandom_range(0, 1)), 3'($urandom), 3'($urandom)};
            op   = 2'($urandom);
            keep = 1'($urandom);
            if (!prevKept)
                for (int j = 0; j < int'($urandom_range(0, 3)); j++) step();
            applyStimulus(op, addr, keep);
        end
        i_req_valid = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
